// File: rtl/retire_pkg.sv
// Shared processor types for the in-order retirement stage: ROB entry layout,
// control bits, the retire FSM state encoding and tag arithmetic.
package retire_pkg;

  localparam int ROB_SIZE_DEFAULT = 16;

  typedef logic [31:0] MemoryWord;

  typedef struct packed {
    logic regwr;
    logic memwr;
    logic flush;
    logic branch_prediction;
  } control_bits;

  typedef struct packed {
    MemoryWord   value;
    logic        ready;
    logic [4:0]  dest_reg;
    logic [31:0] store_addr;
    logic [31:0] redirect_pc;
    control_bits ctrl_bits;
  } rob_entry;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } retire_state_t;

  // Tags run 1..rob_size; tag 0 is reserved as "no tag".
  function automatic logic [31:0] next_tag(input logic [31:0] tag, input int rob_size);
    logic [31:0] last;
    last = 32'(rob_size);
    return (tag == last) ? 32'd1 : tag + 32'd1;
  endfunction

endpackage

// File: rtl/retire.sv
// In-order retirement stage: commits the ROB head to the register file,
// performs the store handshake for memory writes and redirects on flush.
module retire
  import retire_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  rob_entry    rob_head_entry,
  input  logic        rob_empty,
  output logic [31:0] head_tag,
  output logic        retire_valid,
  output logic [31:0] retire_tag,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output MemoryWord   rf_wdata,
  output logic        mt_clear,
  output logic [4:0]  mt_clear_reg,
  output logic [31:0] mt_clear_tag,
  output logic        store_req,
  output logic [31:0] store_addr,
  output MemoryWord   store_data,
  input  logic        store_ack,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [31:0] retired_count
);

  retire_state_t state_reg, state_next;
  logic [31:0]   head_reg, head_next;
  logic [31:0]   count_reg, count_next;

  logic          retire_valid_reg, retire_valid_next;
  logic [31:0]   retire_tag_reg, retire_tag_next;
  logic          rf_we_reg, rf_we_next;
  logic [4:0]    rf_waddr_reg, rf_waddr_next;
  MemoryWord     rf_wdata_reg, rf_wdata_next;
  logic          mt_clear_reg_q, mt_clear_next;
  logic [4:0]    mt_clear_dest_reg, mt_clear_dest_next;
  logic [31:0]   mt_clear_tag_reg, mt_clear_tag_next;
  logic          store_req_reg, store_req_next;
  logic [31:0]   store_addr_reg, store_addr_next;
  MemoryWord     store_data_reg, store_data_next;
  logic          flush_reg, flush_next;
  logic [31:0]   flush_pc_reg, flush_pc_next;

  logic          eligible;
  logic          retire_go;
  logic          unused_bits;

  // The prediction bit only matters to the front end; retirement ignores it.
  assign unused_bits = rob_head_entry.ctrl_bits.branch_prediction;

  assign eligible = !rob_empty && rob_head_entry.ready;

  always_comb begin
    state_next         = state_reg;
    head_next          = head_reg;
    count_next         = count_reg;
    store_req_next     = store_req_reg;
    store_addr_next    = store_addr_reg;
    store_data_next    = store_data_reg;
    retire_valid_next  = 1'b0;
    retire_tag_next    = '0;
    rf_we_next         = 1'b0;
    rf_waddr_next      = '0;
    rf_wdata_next      = '0;
    mt_clear_next      = 1'b0;
    mt_clear_dest_next = '0;
    mt_clear_tag_next  = '0;
    flush_next         = 1'b0;
    flush_pc_next      = '0;
    retire_go          = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (eligible) begin
          if (rob_head_entry.ctrl_bits.memwr) begin
            // Stores retire only once memory has accepted them.
            store_req_next  = 1'b1;
            store_addr_next = rob_head_entry.store_addr;
            store_data_next = rob_head_entry.value;
            state_next      = STORE_WAIT;
          end else begin
            retire_go = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        if (store_ack) begin
          store_req_next = 1'b0;
          retire_go      = 1'b1;
        end
      end
      FLUSH: begin
        if (rob_empty) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase

    if (retire_go) begin
      retire_valid_next = 1'b1;
      retire_tag_next   = head_reg;
      if (rob_head_entry.ctrl_bits.regwr) begin
        rf_we_next         = 1'b1;
        rf_waddr_next      = rob_head_entry.dest_reg;
        rf_wdata_next      = rob_head_entry.value;
        mt_clear_next      = 1'b1;
        mt_clear_dest_next = rob_head_entry.dest_reg;
        mt_clear_tag_next  = head_reg;
      end
      if (rob_head_entry.ctrl_bits.flush) begin
        flush_next    = 1'b1;
        flush_pc_next = rob_head_entry.redirect_pc;
        state_next    = FLUSH;
      end else begin
        state_next = RUN;
      end
      head_next  = next_tag(head_reg, ROB_SIZE);
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= RUN;
      head_reg          <= 32'd1;
      count_reg         <= '0;
      retire_valid_reg  <= 1'b0;
      retire_tag_reg    <= '0;
      rf_we_reg         <= 1'b0;
      rf_waddr_reg      <= '0;
      rf_wdata_reg      <= '0;
      mt_clear_reg_q    <= 1'b0;
      mt_clear_dest_reg <= '0;
      mt_clear_tag_reg  <= '0;
      store_req_reg     <= 1'b0;
      store_addr_reg    <= '0;
      store_data_reg    <= '0;
      flush_reg         <= 1'b0;
      flush_pc_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      head_reg          <= head_next;
      count_reg         <= count_next;
      retire_valid_reg  <= retire_valid_next;
      retire_tag_reg    <= retire_tag_next;
      rf_we_reg         <= rf_we_next;
      rf_waddr_reg      <= rf_waddr_next;
      rf_wdata_reg      <= rf_wdata_next;
      mt_clear_reg_q    <= mt_clear_next;
      mt_clear_dest_reg <= mt_clear_dest_next;
      mt_clear_tag_reg  <= mt_clear_tag_next;
      store_req_reg     <= store_req_next;
      store_addr_reg    <= store_addr_next;
      store_data_reg    <= store_data_next;
      flush_reg         <= flush_next;
      flush_pc_reg      <= flush_pc_next;
    end
  end

  assign head_tag      = head_reg;
  assign retired_count = count_reg;
  assign retire_valid  = retire_valid_reg;
  assign retire_tag    = retire_tag_reg;
  assign rf_we         = rf_we_reg;
  assign rf_waddr      = rf_waddr_reg;
  assign rf_wdata      = rf_wdata_reg;
  assign mt_clear      = mt_clear_reg_q;
  assign mt_clear_reg  = mt_clear_dest_reg;
  assign mt_clear_tag  = mt_clear_tag_reg;
  assign store_req     = store_req_reg;
  assign store_addr    = store_addr_reg;
  assign store_data    = store_data_reg;
  assign flush         = flush_reg;
  assign flush_pc      = flush_pc_reg;

endmodule

// File: tb/tb_retire.sv
// Scoreboard bench for retire: stimulus queues expected retirements and stores
// as entries are allocated; a negedge monitor pops and compares DUT output.
module tb_retire;
  import retire_pkg::*;

  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        reset;
  rob_entry    rob_head_entry;
  logic        rob_empty;
  logic [31:0] head_tag;
  logic        retire_valid;
  logic [31:0] retire_tag;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  MemoryWord   rf_wdata;
  logic        mt_clear;
  logic [4:0]  mt_clear_reg;
  logic [31:0] mt_clear_tag;
  logic        store_req;
  logic [31:0] store_addr;
  MemoryWord   store_data;
  logic        store_ack = 1'b0;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] retired_count;

  retire #(.ROB_SIZE(RS)) dut (
    .clk(clk), .reset(reset), .rob_head_entry(rob_head_entry), .rob_empty(rob_empty),
    .head_tag(head_tag), .retire_valid(retire_valid), .retire_tag(retire_tag),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mt_clear(mt_clear), .mt_clear_reg(mt_clear_reg), .mt_clear_tag(mt_clear_tag),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data), .store_ack(store_ack),
    .flush(flush), .flush_pc(flush_pc), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tag;
    logic        regwr;
    logic [4:0]  dest;
    logic [31:0] value;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] count;
  } exp_ret_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_st_t;

  // Appended only by stimulus; the monitor keeps its own read indices.
  exp_ret_t exp_ret_q[$];
  exp_st_t  exp_st_q[$];

  // ROB model: contents written by stimulus; occupancy = allocated - squashed - retired.
  rob_entry rob_mem [0:31];
  int alloc_total = 0;
  int squashed = 0;
  int retired_seen = 0;
  int occ;
  assign occ = alloc_total - squashed - retired_seen;
  assign rob_empty = (occ == 0);
  assign rob_head_entry = rob_mem[head_tag[4:0]];

  // Stimulus-owned controls.
  logic [31:0] tail = 32'd1;
  logic [31:0] exp_count = '0;
  int fixed_delay = 0;
  bit ack_enable = 1'b1;
  bit force_ack = 1'b0;
  bit spurious_en = 1'b0;
  int timeout_cnt = 0;
  bit done_req = 1'b0;

  // ---------------- store memory responder ----------------
  int ack_cnt = 0;
  int cur_delay = 1;
  always @(negedge clk) begin
    if (reset) begin
      ack_cnt = 0;
      store_ack = force_ack;
    end else if (store_req) begin
      if (ack_cnt == 0) cur_delay = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
      ack_cnt++;
      store_ack = ack_enable && (ack_cnt == cur_delay);
    end else begin
      ack_cnt = 0;
      store_ack = force_ack || (spurious_en && ($urandom_range(0, 3) == 0));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int rd_ret = 0;
  int rd_st = 0;
  logic [31:0] exp_head = 32'd1;
  bit prev_reset = 1'b0;
  bit prev_store = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  int st_len = 0;
  int timeouts_seen = 0;
  bit done_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
  endtask

  always @(negedge clk) begin
    exp_ret_t er;
    exp_st_t  es;
    if (reset) begin
      if (prev_reset) begin
        chk("rst_head_tag", head_tag, 32'd1);
        chk("rst_retired_count", retired_count, 32'd0);
        chk("rst_pulses", {28'd0, retire_valid, rf_we, mt_clear, flush}, 32'd0);
        chk("rst_store_req", {31'd0, store_req}, 32'd0);
        chk("rst_store_addr", store_addr, 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
      end
      rd_ret = exp_ret_q.size();
      rd_st = exp_st_q.size();
      exp_head = 32'd1;
      prev_store = 1'b0;
      st_len = 0;
    end else begin
      if (retire_valid) begin
        retired_seen++;
        if (rd_ret >= exp_ret_q.size()) begin
          total_cnt++;
          $display("FAIL unexpected_retire: got tag %0d required no retirement", retire_tag);
        end else begin
          er = exp_ret_q[rd_ret];
          rd_ret++;
          chk("retire_tag", retire_tag, er.tag);
          chk("rf_we", {31'd0, rf_we}, {31'd0, er.regwr});
          chk("mt_clear", {31'd0, mt_clear}, {31'd0, er.regwr});
          if (er.regwr) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, er.dest});
            chk("rf_wdata", rf_wdata, er.value);
            chk("mt_clear_reg", {27'd0, mt_clear_reg}, {27'd0, er.dest});
            chk("mt_clear_tag", mt_clear_tag, er.tag);
          end
          chk("flush", {31'd0, flush}, {31'd0, er.fl});
          if (er.fl) chk("flush_pc", flush_pc, er.pc);
          chk("retired_count", retired_count, er.count);
          $display("retire tag=%0d regwr=%0d flush=%0d count=%0d", retire_tag, rf_we, flush, retired_count);
        end
        exp_head = (exp_head == RS) ? 32'd1 : exp_head + 32'd1;
      end else begin
        chk("idle_pulses", {29'd0, rf_we, mt_clear, flush}, 32'd0);
      end
      chk("head_tag", head_tag, exp_head);

      if (store_req) begin
        if (!prev_store) begin
          if (rd_st >= exp_st_q.size()) begin
            total_cnt++;
            $display("FAIL unexpected_store: got addr %0h required no store", store_addr);
          end else begin
            es = exp_st_q[rd_st];
            rd_st++;
            chk("store_addr", store_addr, es.addr);
            chk("store_data", store_data, es.data);
            $display("store addr=%0h data=%0h", store_addr, store_data);
          end
        end else begin
          chk("store_addr_stable", store_addr, prev_addr);
          chk("store_data_stable", store_data, prev_data);
        end
        st_len++;
      end else if (prev_store) begin
        chk("store_req_len", st_len, cur_delay);
        st_len = 0;
      end
      prev_store = store_req;
      prev_addr = store_addr;
      prev_data = store_data;

      if (timeout_cnt != timeouts_seen) begin
        total_cnt++;
        $display("FAIL timeout: got %0d expired waits required 0", timeout_cnt - timeouts_seen);
        timeouts_seen = timeout_cnt;
      end
      if (done_req && !done_seen) begin
        chk("leftover_retires", rd_ret, exp_ret_q.size());
        chk("leftover_stores", rd_st, exp_st_q.size());
        done_seen = 1'b1;
      end
    end
    prev_reset = reset;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rob_entry mk(input bit regwr, input bit memwr, input bit fl,
                                  input logic [4:0] dest, input logic [31:0] value,
                                  input logic [31:0] addr, input logic [31:0] pc, input bit rdy);
    rob_entry e;
    e = '0;
    e.value = value;
    e.ready = rdy;
    e.dest_reg = dest;
    e.store_addr = addr;
    e.redirect_pc = pc;
    e.ctrl_bits.regwr = regwr;
    e.ctrl_bits.memwr = memwr;
    e.ctrl_bits.flush = fl;
    e.ctrl_bits.branch_prediction = fl;
    return e;
  endfunction

  task automatic alloc(input rob_entry e, input bit expect_it);
    exp_ret_t er;
    exp_st_t  es;
    rob_mem[tail[4:0]] = e;
    if (expect_it) begin
      exp_count = exp_count + 32'd1;
      er.tag = tail;
      er.regwr = e.ctrl_bits.regwr;
      er.dest = e.dest_reg;
      er.value = e.value;
      er.fl = e.ctrl_bits.flush;
      er.pc = e.redirect_pc;
      er.count = exp_count;
      exp_ret_q.push_back(er);
      if (e.ctrl_bits.memwr) begin
        es.addr = e.store_addr;
        es.data = e.value;
        exp_st_q.push_back(es);
      end
    end
    tail = (tail == RS) ? 32'd1 : tail + 32'd1;
    alloc_total++;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    squashed = alloc_total - retired_seen;
    tail = 32'd1;
    exp_count = '0;
    for (int i = 0; i < 32; i++) rob_mem[i] = '0;
  endtask

  task automatic wait_occ(input int target, input int budget);
    int k;
    k = 0;
    while (occ != target && k < budget) begin
      step();
      k++;
    end
    if (occ != target) timeout_cnt++;
  endtask

  initial begin
    logic [31:0] decoy_tag;
    bit flush_pending;
    int n;
    int kind;
    for (int i = 0; i < 32; i++) rob_mem[i] = '0;
    do_reset(3);

    // ALU entry, tag 1, writes r5.
    alloc(mk(1'b1, 1'b0, 1'b0, 5'd5, 32'hDEAD, 32'h0, 32'h0, 1'b1), 1'b1);
    wait_occ(0, 20);

    // Store tag 2, ack in the third request cycle.
    fixed_delay = 3;
    alloc(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'd7, 32'h100, 32'h0, 1'b1), 1'b1);
    wait_occ(0, 30);
    fixed_delay = 0;

    // Flush branch tag 3 followed by a ready entry that must not retire.
    alloc(mk(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h40, 1'b1), 1'b1);
    decoy_tag = tail;
    alloc(mk(1'b1, 1'b0, 1'b0, 5'd9, 32'hBAD, 32'h0, 32'h0, 1'b1), 1'b0);
    wait_occ(1, 20);
    repeat (4) step();
    squashed++;
    tail = decoy_tag;
    repeat (2) step();

    // 17 back-to-back ALU retirements from head 1, wrapping the tag.
    do_reset(2);
    n = 0;
    while (n < 17) begin
      if (occ < RS) begin
        alloc(mk(1'(n % 2), 1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom, 32'h0, 32'h0, 1'b1), 1'b1);
        n++;
      end
      step();
    end
    wait_occ(0, 40);

    // Randomized traffic with late readiness, stores, flushes and spurious acks.
    spurious_en = 1'b1;
    flush_pending = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (flush_pending && occ == 0) flush_pending = 1'b0;
      if (!flush_pending && occ < RS && $urandom_range(0, 2) != 0) begin
        kind = int'($urandom_range(0, 9));
        if (kind < 2)
          alloc(mk(1'b0, 1'b1, 1'b0, 5'd0, $urandom, $urandom, 32'h0, 1'($urandom_range(0, 1))), 1'b1);
        else if (kind == 2) begin
          alloc(mk(1'($urandom_range(0, 1)), 1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom,
                   32'h0, $urandom, 1'($urandom_range(0, 1))), 1'b1);
          flush_pending = 1'b1;
        end else
          alloc(mk(1'($urandom_range(0, 1)), 1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom,
                   32'h0, 32'h0, 1'($urandom_range(0, 1))), 1'b1);
      end
      for (int t = 1; t <= RS; t++)
        if (!rob_mem[t].ready && $urandom_range(0, 3) == 0) rob_mem[t].ready = 1'b1;
      step();
    end
    for (int t = 1; t <= RS; t++) rob_mem[t].ready = 1'b1;
    wait_occ(0, 300);
    spurious_en = 1'b0;
    repeat (2) step();

    // Reset in the middle of an outstanding store; ack arrives afterwards.
    ack_enable = 1'b0;
    alloc(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h55, 32'h200, 32'h0, 1'b1), 1'b1);
    n = 0;
    while (!store_req && n < 10) begin
      step();
      n++;
    end
    if (!store_req) timeout_cnt++;
    step();
    do_reset(2);
    force_ack = 1'b1;
    repeat (4) step();
    force_ack = 1'b0;
    ack_enable = 1'b1;
    repeat (2) step();

    done_req = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
